// File: rtl/correlation_pkg.sv
// rtl/correlation_pkg.sv - shared defaults, value types and scan states for the correlation peak finder
package correlation_pkg;

    localparam int DEF_NUM_SAMPLES       = 100;
    localparam int DEF_MAX_SAMPLES_DELAY = 11;
    localparam int DEF_NUM_BITS_SAMPLE   = 12;
    localparam int DEF_NUM_XCORRS        = 6;

    localparam int DEF_NUM_BITS_XCORR = 2 * DEF_NUM_BITS_SAMPLE + $clog2(DEF_NUM_SAMPLES);
    localparam int DEF_NUM_BITS_LAG   = $clog2(DEF_MAX_SAMPLES_DELAY + 1) + 1;
    localparam int DEF_XCORR_LEN      = 2 * DEF_MAX_SAMPLES_DELAY + 1;

    typedef logic signed [DEF_NUM_BITS_XCORR-1:0] xcorr_t;
    typedef logic signed [DEF_NUM_BITS_LAG-1:0]   lag_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } peak_state_t;

endpackage

// File: rtl/peak_tracker.sv
// rtl/peak_tracker.sv - running signed maximum and its index for one correlation vector
module peak_tracker #(
    parameter int W  = 31,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          first,
    input  logic          enable,
    input  logic [W-1:0]  value,
    input  logic [IW-1:0] idx,
    output logic [W-1:0]  best,
    output logic [IW-1:0] bestIdx
);

    logic [W-1:0]  r_best;
    logic [IW-1:0] r_best_idx;
    logic          w_greater;

    // Strict compare keeps the earliest index on ties, i.e. the most negative lag.
    assign w_greater = $signed(value) > $signed(r_best);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best     <= '0;
            r_best_idx <= '0;
        end else if (enable && (first || w_greater)) begin
            r_best     <= value;
            r_best_idx <= idx;
        end
    end

    assign best    = r_best;
    assign bestIdx = r_best_idx;

endmodule

// File: rtl/xcorr_peak_finder.sv
// rtl/xcorr_peak_finder.sv - per-pair argmax lag of cross-correlation vectors; optional peakOut via PEAK_VALUE_OUT_EN
module xcorr_peak_finder
    import correlation_pkg::*;
#(
    parameter int NUM_SAMPLES       = DEF_NUM_SAMPLES,
    parameter int MAX_SAMPLES_DELAY = DEF_MAX_SAMPLES_DELAY,
    parameter int NUM_BITS_SAMPLE   = DEF_NUM_BITS_SAMPLE,
    parameter int NUM_XCORRS        = DEF_NUM_XCORRS,
    localparam int L              = 2 * MAX_SAMPLES_DELAY + 1,
    localparam int NUM_BITS_XCORR = 2 * NUM_BITS_SAMPLE + $clog2(NUM_SAMPLES),
    localparam int NUM_BITS_LAG   = $clog2(MAX_SAMPLES_DELAY + 1) + 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          validIn,
    input  logic [NUM_XCORRS-1:0][L-1:0][NUM_BITS_XCORR-1:0] xCorrIn,
    output logic                                          busy,
    output logic                                          validOut,
    output logic [NUM_XCORRS-1:0][NUM_BITS_LAG-1:0]       lagOut,
    output logic                                          overflow
`ifdef PEAK_VALUE_OUT_EN
    ,
    output logic [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0]     peakOut
`endif
);

    localparam int IW = $clog2(L);

    peak_state_t r_state;
    peak_state_t w_next_state;

    logic [IW-1:0]                                    r_idx;
    logic [NUM_XCORRS-1:0][L-1:0][NUM_BITS_XCORR-1:0] r_snap;
    logic [NUM_XCORRS-1:0][NUM_BITS_LAG-1:0]          r_lag;
    logic                                             r_valid_out;
    logic                                             r_overflow;

    logic                                      w_scan;
    logic                                      w_first;
    logic                                      w_last;
    logic [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0] w_best;
    logic [NUM_XCORRS-1:0][IW-1:0]             w_best_idx;

    assign w_scan  = (r_state == SCAN);
    assign w_first = w_scan && (r_idx == '0);
    assign w_last  = (r_idx == IW'(L - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (validIn) w_next_state = SCAN;
            SCAN:    if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Snapshot frees the upstream stage to keep updating every sample.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && validIn) begin
            r_snap <= xCorrIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_lag       <= '0;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_valid_out <= (r_state == DONE);
            if (r_state == SCAN) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end
            if (r_state == DONE) begin
                for (int p = 0; p < NUM_XCORRS; p++) begin
                    r_lag[p] <= NUM_BITS_LAG'(w_best_idx[p]) - NUM_BITS_LAG'(MAX_SAMPLES_DELAY);
                end
            end
            if (validIn && r_state != IDLE) begin
                r_overflow <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_XCORRS; p++) begin : g_trk
        peak_tracker #(
            .W  (NUM_BITS_XCORR),
            .IW (IW)
        ) u_trk (
            .clk     (clk),
            .rst     (rst),
            .first   (w_first),
            .enable  (w_scan),
            .value   (r_snap[p][r_idx]),
            .idx     (r_idx),
            .best    (w_best[p]),
            .bestIdx (w_best_idx[p])
        );
    end

`ifdef PEAK_VALUE_OUT_EN
    logic [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0] r_peak;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak <= '0;
        end else if (r_state == DONE) begin
            r_peak <= w_best;
        end
    end

    assign peakOut = r_peak;
`else
    // Peak values only leave the block when peakOut is built in.
    logic w_best_unused;
    assign w_best_unused = ^w_best;
`endif

    assign busy     = (r_state != IDLE);
    assign validOut = r_valid_out;
    assign lagOut   = r_lag;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// tb/tb_xcorr_peak_finder.sv - self-checking bench for xcorr_peak_finder
module tb_xcorr_peak_finder;

    localparam int M  = 11;
    localparam int L  = 2 * M + 1;
    localparam int W  = 31;
    localparam int NX = 6;
    localparam int LW = 5;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          validIn;
    logic [NX-1:0][L-1:0][W-1:0]   xCorrIn;
    logic                          busy;
    logic                          validOut;
    logic [NX-1:0][LW-1:0]         lagOut;
    logic                          overflow;
`ifdef PEAK_VALUE_OUT_EN
    logic [NX-1:0][W-1:0]          peakOut;
`endif

    xcorr_peak_finder dut (
        .clk      (clk),
        .rst      (rst),
        .validIn  (validIn),
        .xCorrIn  (xCorrIn),
        .busy     (busy),
        .validOut (validOut),
        .lagOut   (lagOut),
        .overflow (overflow)
`ifdef PEAK_VALUE_OUT_EN
        ,
        .peakOut  (peakOut)
`endif
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [NX-1:0][LW-1:0] lag;
        logic [NX-1:0][W-1:0]  peak;
        int                    tpair;
        int                    tlag;
        int                    acc;
    } exp_t;

    typedef struct {
        int     pair;
        longint base;
        int     i1;
        longint v1;
        int     i2;
        longint v2;
        bit     zero_others;
        int     exp_lag;
    } vec_rec_t;

    vec_rec_t              tbl[7];
    exp_t                  sb_q[$];
    exp_t                  mon_e;
    logic [NX-1:0][LW-1:0] last_lag = '0;
    int                    checks = 0;
    int                    fails  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build(input vec_rec_t r, output logic [NX-1:0][L-1:0][W-1:0] v, output exp_t e);
        logic signed [W-1:0] best;
        int                  bi;
        for (int p = 0; p < NX; p++) begin
            for (int j = 0; j < L; j++) begin
                if (p == r.pair)        v[p][j] = W'(r.base);
                else if (r.zero_others) v[p][j] = '0;
                else                    v[p][j] = W'($urandom);
            end
        end
        if (r.i1 >= 0) v[r.pair][r.i1] = W'(r.v1);
        if (r.i2 >= 0) v[r.pair][r.i2] = W'(r.v2);
        for (int p = 0; p < NX; p++) begin
            best = $signed(v[p][0]);
            bi   = 0;
            for (int j = 1; j < L; j++) begin
                if ($signed(v[p][j]) > best) begin
                    best = $signed(v[p][j]);
                    bi   = j;
                end
            end
            e.lag[p]  = LW'(bi - M);
            e.peak[p] = best;
        end
        e.tpair = r.pair;
        e.tlag  = r.exp_lag;
        e.acc   = 0;
    endtask

    // Called right after a falling edge; validIn is held for exactly one cycle.
    task automatic send(input vec_rec_t r, input bit push);
        logic [NX-1:0][L-1:0][W-1:0] v;
        exp_t                        e;
        build(r, v, e);
        e.acc   = cyc + 1;
        xCorrIn = v;
        validIn = 1'b1;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        validIn = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 64'(sb_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && validOut) begin
            if (sb_q.size() == 0) begin
                check("validOut_with_empty_queue", 64'(validOut), 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("latency", 64'(cyc - mon_e.acc), 24);
                for (int p = 0; p < NX; p++) begin
                    check($sformatf("lag_pair%0d", p), 64'($signed(lagOut[p])), 64'($signed(mon_e.lag[p])));
`ifdef PEAK_VALUE_OUT_EN
                    check($sformatf("peak_pair%0d", p), 64'($signed(peakOut[p])), 64'($signed(mon_e.peak[p])));
`endif
                end
                check("lag_target", 64'($signed(lagOut[mon_e.tpair])), 64'(mon_e.tlag));
                last_lag = lagOut;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 14, 1000, -1, 0, 1'b0, 3};
        tbl[1] = '{1, -5, 0, -1, -1, 0, 1'b0, -11};
        tbl[2] = '{2, -1073741824, 22, 1073741823, -1, 0, 1'b0, 11};
        tbl[3] = '{3, 10, 4, 77, 18, 77, 1'b0, -7};
        tbl[4] = '{4, 0, -1, 0, -1, 0, 1'b1, -11};
        tbl[5] = '{5, -1073741824, 11, -1073741823, -1, 0, 1'b0, 0};
        tbl[6] = '{0, 1073741822, 7, 1073741823, 8, -1073741824, 1'b0, -4};

        rst     = 1'b1;
        validIn = 1'b0;
        xCorrIn = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 0);
        check("reset_validOut", 64'(validOut), 0);
        check("reset_overflow", 64'(overflow), 0);
        check("reset_lagOut", 64'(lagOut), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i], 1'b1);
            check("busy_after_accept", 64'(busy), 1);
            wait_drain();
            repeat (3) @(negedge clk);
            check("lag_hold", 64'(lagOut), 64'(last_lag));
        end
        check("overflow_clear", 64'(overflow), 0);

        // Request arriving mid-scan is dropped and latches overflow.
        send(tbl[0], 1'b1);
        repeat (4) @(negedge clk);
        send(tbl[1], 1'b0);
        check("overflow_set", 64'(overflow), 1);
        wait_drain();
        repeat (5) @(negedge clk);
        check("overflow_sticky", 64'(overflow), 1);

        // New request in the same cycle as validOut is accepted.
        send(tbl[3], 1'b1);
        for (int i = 0; i < 100 && !validOut; i++) @(negedge clk);
        check("b2b_validOut_seen", 64'(validOut), 1);
        send(tbl[1], 1'b1);
        check("b2b_busy", 64'(busy), 1);
        wait_drain();

        // Reset at scan index 10 aborts without a result.
        send(tbl[2], 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 0);
        check("abort_validOut", 64'(validOut), 0);
        check("abort_lagOut", 64'(lagOut), 0);
        check("abort_overflow", 64'(overflow), 0);
        repeat (30) @(negedge clk);
        send(tbl[0], 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
